// File: rtl/div_ctrl_if.sv
// Handshake and data bundle between the EXE stage and the iterative divider.
// The EXE side drives the master modport; the divider uses the slave modport.
interface div_ctrl_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  div_enable;
   logic                  div_signed;
   logic [DATA_WIDTH-1:0] dividend;
   logic [DATA_WIDTH-1:0] divisor;
   logic                  result_ack;
   logic                  flush;
   logic                  busy;
   logic                  div_complete;
   logic [DATA_WIDTH-1:0] quotient;
   logic [DATA_WIDTH-1:0] remainder;

   modport master (
      output div_enable, div_signed, dividend, divisor, result_ack, flush,
      input  busy, div_complete, quotient, remainder
   );

   modport slave (
      input  div_enable, div_signed, dividend, divisor, result_ack, flush,
      output busy, div_complete, quotient, remainder
   );
endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU with its sequencer.
// state | meaning
// IDLE  | waiting for div_enable; operands latched on the starting edge
// RUN   | one restoring step per cycle, DATA_WIDTH cycles
// FIX   | sign correction of quotient/remainder into output registers
// DONE  | results valid and held until result_ack
module div_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic       clk,
   input  logic       reset,
   div_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                  r_state;
   logic [CNT_WIDTH-1:0]    r_cnt;
   logic [2*DATA_WIDTH-1:0] r_acc;
   logic [DATA_WIDTH-1:0]   r_divisor;
   logic                    r_neg_q;
   logic                    r_neg_r;
   logic                    r_busy;
   logic                    r_done;
   logic [DATA_WIDTH-1:0]   r_quotient;
   logic [DATA_WIDTH-1:0]   r_remainder;

   logic                    w_dvd_neg;
   logic                    w_dvs_neg;
   logic [DATA_WIDTH-1:0]   w_dvd_abs;
   logic [DATA_WIDTH-1:0]   w_dvs_abs;
   logic                    w_ge;
   logic [DATA_WIDTH-1:0]   w_sub;
   logic [2*DATA_WIDTH-1:0] w_step;
   logic [DATA_WIDTH-1:0]   w_raw_q;
   logic [DATA_WIDTH-1:0]   w_raw_r;

   assign w_dvd_neg = bus.div_signed & bus.dividend[DATA_WIDTH-1];
   assign w_dvs_neg = bus.div_signed & bus.divisor[DATA_WIDTH-1];
   assign w_dvd_abs = w_dvd_neg ? (~bus.dividend + ONE) : bus.dividend;
   assign w_dvs_abs = w_dvs_neg ? (~bus.divisor + ONE) : bus.divisor;

   // The shifted partial remainder can reach DATA_WIDTH+1 bits when the divisor
   // is above half range, so the compare keeps the bit shifted out of the top.
   assign w_ge  = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1] >= {1'b0, r_divisor};
   assign w_sub = r_acc[2*DATA_WIDTH-2:DATA_WIDTH-1] - r_divisor;

   always_comb begin
      w_step = {r_acc[2*DATA_WIDTH-2:0], 1'b0};
      if (w_ge) begin
         w_step = {w_sub, r_acc[DATA_WIDTH-2:0], 1'b1};
      end
   end

   assign w_raw_q = r_acc[DATA_WIDTH-1:0];
   assign w_raw_r = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_divisor   <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (bus.flush) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.div_enable) begin
                  r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                  r_neg_r   <= w_dvd_neg;
                  r_divisor <= w_dvs_abs;
                  r_acc     <= {{DATA_WIDTH{1'b0}}, w_dvd_abs};
                  r_cnt     <= '0;
                  r_busy    <= 1'b1;
                  if (bus.divisor == '0) begin
                     // Divide by zero bypasses the iteration entirely.
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_quotient  <= '1;
                     r_remainder <= bus.dividend;
                  end else begin
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_acc <= w_step;
               r_cnt <= r_cnt + CNT_WIDTH'(1);
               if (r_cnt == CNT_LAST) begin
                  r_state <= FIX;
               end
            end
            FIX: begin
               r_quotient  <= r_neg_q ? (~w_raw_q + ONE) : w_raw_q;
               r_remainder <= r_neg_r ? (~w_raw_r + ONE) : w_raw_r;
               r_done      <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               if (bus.result_ack) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = r_busy;
   assign bus.div_complete = r_done;
   assign bus.quotient     = r_quotient;
   assign bus.remainder    = r_remainder;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl: latency, sign handling, divide by zero,
// overflow, flush cancellation, result hold and asynchronous reset.
module tb_div_ctrl;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   div_ctrl_if #(.DATA_WIDTH(32)) bus ();

   div_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Starts a divide, counts cycles to div_complete, holds DONE for 'hold' cycles
   // while scrambling operands, then acks and checks the return to IDLE.
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] qe,
                          input logic [31:0] re, input int lat, input int hold);
      int n;
      bus.div_signed = sgn;
      bus.dividend   = a;
      bus.divisor    = b;
      bus.div_enable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.div_complete && n < 40);
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " busy"}, {31'b0, bus.busy}, 32'd1);
      check({tag, " quotient"}, bus.quotient, qe);
      check({tag, " remainder"}, bus.remainder, re);
      for (int i = 0; i < hold; i++) begin
         bus.dividend   = $urandom;
         bus.divisor    = $urandom;
         bus.div_signed = ~bus.div_signed;
         tick();
         check({tag, " hold complete"}, {31'b0, bus.div_complete}, 32'd1);
         check({tag, " hold quotient"}, bus.quotient, qe);
         check({tag, " hold remainder"}, bus.remainder, re);
      end
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
      bus.div_enable = 1'b0;
      check({tag, " ack complete"}, {31'b0, bus.div_complete}, 32'd0);
      check({tag, " ack busy"}, {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b1;
      bus.div_enable = 1'b0;
      bus.div_signed = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;
      bus.result_ack = 1'b0;
      bus.flush      = 1'b0;

      tick();
      tick();
      check("reset busy", {31'b0, bus.busy}, 32'd0);
      check("reset complete", {31'b0, bus.div_complete}, 32'd0);
      check("reset quotient", bus.quotient, 32'd0);
      check("reset remainder", bus.remainder, 32'd0);
      #2 reset = 1'b0;
      tick();

      run_div("u 7/2", 1'b0, 32'd7, 32'd2, 32'd3, 32'd1, 34, 2);
      tick();
      run_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 5);
      run_div("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);
      run_div("s div0", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 1);
      run_div("u div0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0);
      run_div("s ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0);
      run_div("u ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 0);
      run_div("u big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 34, 0);

      // Flush during RUN: launched in cycle 0, flush raised in cycle 10.
      bus.div_signed = 1'b0;
      bus.dividend   = 32'd1000;
      bus.divisor    = 32'd3;
      bus.div_enable = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         check("flush pre complete", {31'b0, bus.div_complete}, 32'd0);
      end
      bus.flush = 1'b1;
      tick();
      check("flush busy", {31'b0, bus.busy}, 32'd0);
      check("flush complete", {31'b0, bus.div_complete}, 32'd0);
      bus.flush      = 1'b0;
      bus.div_enable = 1'b0;
      tick();
      run_div("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);

      // Asynchronous reset between clock edges in the middle of RUN.
      bus.dividend   = 32'd7;
      bus.divisor    = 32'd2;
      bus.div_enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("pre areset busy", {31'b0, bus.busy}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("areset busy", {31'b0, bus.busy}, 32'd0);
      check("areset complete", {31'b0, bus.div_complete}, 32'd0);
      check("areset quotient", bus.quotient, 32'd0);
      check("areset remainder", bus.remainder, 32'd0);
      bus.div_enable = 1'b0;
      #2 reset = 1'b0;
      tick();
      check("post areset busy", {31'b0, bus.busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
